// File: rtl/block_pos_ctrl_if.sv
// Button inputs and block-position outputs of block_pos_ctrl.
// The slave modport is the controller side and the master modport is the driver/observer side.
interface block_pos_ctrl_if #(
    parameter int POS_W = 11
);
    logic             left;
    logic             right;
    logic             up;
    logic             down;
    logic             centre;
    logic [POS_W-1:0] blkpos_x;
    logic [POS_W-1:0] blkpos_y;
    logic             pos_upd;
    logic             tick;

    modport slave (
        input  left, right, up, down, centre,
        output blkpos_x, blkpos_y, pos_upd, tick
    );

    modport master (
        output left, right, up, down, centre,
        input  blkpos_x, blkpos_y, pos_upd, tick
    );
endinterface

// File: rtl/block_pos_ctrl.sv
// Block position controller: synchronises and debounces five buttons, generates a step tick,
// and moves, saturates and re-centres the block position once per tick.
//   state       | meaning
//   ST_INIT     | hold at home until a tick sees all buttons released
//   ST_RUN      | apply one step per tick; centre re-homes the block
//   ST_RECENTER | hold at home until a tick sees centre released
module block_pos_ctrl #(
    parameter int TICK_DIV   = 1666667,
    parameter int DEB_CYCLES = 1000000,
    parameter int STEP       = 4,
    parameter int X_MIN      = 11,
    parameter int X_MAX      = 1396,
    parameter int Y_MIN      = 11,
    parameter int Y_MAX      = 854,
    parameter int X_HOME     = 700,
    parameter int Y_HOME     = 450,
    parameter int POS_W      = 11
) (
    input logic               clk,
    input logic               rst_n,
    block_pos_ctrl_if.slave   bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int SW = POS_W + 2;
    localparam int B_L = 0;
    localparam int B_R = 1;
    localparam int B_U = 2;
    localparam int B_D = 3;
    localparam int B_C = 4;

    localparam logic signed [SW-1:0] XMIN_S = SW'(X_MIN);
    localparam logic signed [SW-1:0] XMAX_S = SW'(X_MAX);
    localparam logic signed [SW-1:0] YMIN_S = SW'(Y_MIN);
    localparam logic signed [SW-1:0] YMAX_S = SW'(Y_MAX);
    localparam logic signed [SW-1:0] STEP_S = SW'(STEP);
    localparam logic [POS_W-1:0]     XHOME  = POS_W'(X_HOME);
    localparam logic [POS_W-1:0]     YHOME  = POS_W'(Y_HOME);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_RECENTER} state_e;

    logic [4:0]       raw_btn;
    logic [4:0]       sync1_q, sync2_q, deb_q;
    logic [DW-1:0]    deb_cnt_q [5];
    logic [TW-1:0]    tick_cnt_q;
    logic             tick_q;
    logic             upd_q;
    logic [POS_W-1:0] pos_x_q, pos_y_q;
    logic [POS_W-1:0] pos_x_d, pos_y_d;
    logic signed [SW-1:0] dx, dy, sum_x, sum_y;
    state_e           state_q;

    assign raw_btn = {bus.centre, bus.down, bus.up, bus.right, bus.left};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 5; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw_btn;
            sync2_q <= sync1_q;
            for (int i = 0; i < 5; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    deb_q[i]     <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Opposing buttons cancel; sums are wide enough that saturation never sees a wrapped value.
    always_comb begin
        dx = '0;
        dy = '0;
        if (deb_q[B_R] && !deb_q[B_L]) dx = STEP_S;
        if (deb_q[B_L] && !deb_q[B_R]) dx = -STEP_S;
        if (deb_q[B_D] && !deb_q[B_U]) dy = STEP_S;
        if (deb_q[B_U] && !deb_q[B_D]) dy = -STEP_S;
        sum_x = $signed({2'b00, pos_x_q}) + dx;
        sum_y = $signed({2'b00, pos_y_q}) + dy;
        pos_x_d = sum_x[POS_W-1:0];
        pos_y_d = sum_y[POS_W-1:0];
        if (sum_x < XMIN_S) pos_x_d = POS_W'(X_MIN);
        if (sum_x > XMAX_S) pos_x_d = POS_W'(X_MAX);
        if (sum_y < YMIN_S) pos_y_d = POS_W'(Y_MIN);
        if (sum_y > YMAX_S) pos_y_d = POS_W'(Y_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            upd_q      <= 1'b0;
            pos_x_q    <= XHOME;
            pos_y_q    <= YHOME;
            state_q    <= ST_INIT;
        end else begin
            tick_q     <= (tick_cnt_q == TW'(TICK_DIV - 1));
            tick_cnt_q <= (tick_cnt_q == TW'(TICK_DIV - 1)) ? '0 : tick_cnt_q + TW'(1);
            upd_q      <= 1'b0;
            if (tick_q) begin
                case (state_q)
                    ST_INIT: begin
                        if (deb_q == '0) state_q <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (deb_q[B_C]) begin
                            pos_x_q <= XHOME;
                            pos_y_q <= YHOME;
                            upd_q   <= (pos_x_q != XHOME) || (pos_y_q != YHOME);
                            state_q <= ST_RECENTER;
                        end else begin
                            pos_x_q <= pos_x_d;
                            pos_y_q <= pos_y_d;
                            upd_q   <= (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
                        end
                    end
                    ST_RECENTER: begin
                        if (!deb_q[B_C]) state_q <= ST_RUN;
                    end
                    default: state_q <= ST_INIT;
                endcase
            end
        end
    end

    assign bus.blkpos_x = pos_x_q;
    assign bus.blkpos_y = pos_y_q;
    assign bus.pos_upd  = upd_q;
    assign bus.tick     = tick_q;
endmodule

// File: tb/tb_block_pos_ctrl.sv
// Directed bench for block_pos_ctrl with TICK_DIV=8, DEB_CYCLES=4: vector table plus hand sequences,
// with a free-running monitor on tick period and output stability between ticks.
module tb_block_pos_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    block_pos_ctrl_if #(.POS_W(11)) bus ();

    block_pos_ctrl #(.TICK_DIV(8), .DEB_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;
    int cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Button vector order {centre, down, up, right, left}
    task automatic apply(input logic [4:0] b);
        bus.left   = b[0];
        bus.right  = b[1];
        bus.up     = b[2];
        bus.down   = b[3];
        bus.centre = b[4];
    endtask

    // Returns 1 ns after the negedge following a tick, when pos_upd has been counted.
    task automatic wait_tick();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.tick && k < 40);
        if (!bus.tick) begin
            errors++;
            checks++;
            $display("FAIL tick_timeout: got 0 expected 1");
        end
        @(negedge clk);
        #1;
    endtask

    logic rst_at_edge = 1'b0;
    always @(posedge clk) rst_at_edge <= rst_n;

    logic        prev_tick = 1'b0;
    logic [10:0] prev_x = '0, prev_y = '0;
    int          last_tick = -1;
    always @(negedge clk) begin
        cyc++;
        if (bus.pos_upd) upd_cnt++;
        if (rst_at_edge) begin
            if (!prev_tick) begin
                checks++;
                if (bus.blkpos_x !== prev_x || bus.blkpos_y !== prev_y || bus.pos_upd !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_between_ticks: got x=%0d y=%0d upd=%0b expected x=%0d y=%0d upd=0",
                             bus.blkpos_x, bus.blkpos_y, bus.pos_upd, prev_x, prev_y);
                end
            end else begin
                check("upd_iff_changed", int'(bus.pos_upd),
                      int'((bus.blkpos_x != prev_x) || (bus.blkpos_y != prev_y)));
            end
            if (bus.tick) begin
                if (last_tick >= 0) check("tick_period", cyc - last_tick, 8);
                last_tick = cyc;
            end
        end else begin
            last_tick = -1;
        end
        prev_tick = bus.tick;
        prev_x    = bus.blkpos_x;
        prev_y    = bus.blkpos_y;
    end

    typedef struct {
        logic [4:0] btn;
        int         ticks;
        int         ex;
        int         ey;
        int         eupd;
    } vec_t;

    vec_t vecs [12];

    task automatic run_vec(input int i);
        int u0;
        u0 = upd_cnt;
        apply(vecs[i].btn);
        for (int t = 0; t < vecs[i].ticks; t++) wait_tick();
        check($sformatf("vec%0d_x", i), int'(bus.blkpos_x), vecs[i].ex);
        check($sformatf("vec%0d_y", i), int'(bus.blkpos_y), vecs[i].ey);
        check($sformatf("vec%0d_upd", i), upd_cnt - u0, vecs[i].eupd);
    endtask

    task automatic expect_pos(input string name, input int ex, input int ey, input int u0, input int eupd);
        check({name, "_x"}, int'(bus.blkpos_x), ex);
        check({name, "_y"}, int'(bus.blkpos_y), ey);
        check({name, "_upd"}, upd_cnt - u0, eupd);
    endtask

    initial begin
        int k;
        int u0;
        //                btn       ticks  x     y    upd
        vecs[0]  = '{5'b00000,   2,  700,  450,   0};
        vecs[1]  = '{5'b00010,   5,  720,  450,   5};
        vecs[2]  = '{5'b00100,   3,  720,  438,   3};
        vecs[3]  = '{5'b00000,   1,  720,  438,   0};
        vecs[4]  = '{5'b01011,   2,  704,  458,   2};
        vecs[5]  = '{5'b00001, 200,   11,  458, 174};
        vecs[6]  = '{5'b00010,   1,   15,  458,   1};
        vecs[7]  = '{5'b01000, 110,   15,  854,  99};
        vecs[8]  = '{5'b01100,   1,   15,  854,   0};
        vecs[9]  = '{5'b00010, 360, 1396,  854, 346};
        vecs[10] = '{5'b00101,   2, 1388,  846,   2};
        vecs[11] = '{5'b00000,   1, 1388,  846,   0};

        apply(5'b00000);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_x", int'(bus.blkpos_x), 700);
        check("rst_y", int'(bus.blkpos_y), 450);
        check("rst_upd", int'(bus.pos_upd), 0);
        check("rst_tick", int'(bus.tick), 0);
        rst_n = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.tick && k < 40);
        check("first_tick_delay", k, 8);
        @(negedge clk);
        #1;

        for (int i = 0; i <= 3; i++) run_vec(i);

        // Centre held 10 cycles with right also held: one re-home, then right waits
        u0 = upd_cnt;
        apply(5'b10010);
        repeat (10) @(negedge clk);
        apply(5'b00010);
        wait_tick();
        expect_pos("ctr_home", 700, 450, u0, 1);
        u0 = upd_cnt;
        wait_tick();
        expect_pos("ctr_release", 700, 450, u0, 0);
        u0 = upd_cnt;
        wait_tick();
        expect_pos("ctr_resume", 704, 450, u0, 1);
        apply(5'b00000);

        for (int i = 4; i <= 11; i++) run_vec(i);

        // Three-cycle glitch on right must not reach the debounced value
        u0 = upd_cnt;
        apply(5'b00010);
        repeat (3) @(negedge clk);
        apply(5'b00000);
        wait_tick();
        wait_tick();
        expect_pos("glitch", 1388, 846, u0, 0);

        // Reset mid-hold, then INIT waits for release
        u0 = upd_cnt;
        apply(5'b00010);
        wait_tick();
        expect_pos("pre_rst", 1392, 846, u0, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_x", int'(bus.blkpos_x), 700);
        check("midrst_y", int'(bus.blkpos_y), 450);
        check("midrst_upd", int'(bus.pos_upd), 0);
        rst_n = 1'b1;
        #1;
        u0 = upd_cnt;
        for (int t = 0; t < 3; t++) wait_tick();
        expect_pos("init_hold", 700, 450, u0, 0);
        apply(5'b00000);
        u0 = upd_cnt;
        wait_tick();
        expect_pos("init_exit", 700, 450, u0, 0);
        apply(5'b00010);
        u0 = upd_cnt;
        wait_tick();
        expect_pos("post_init_step", 704, 450, u0, 1);
        apply(5'b00000);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
